drive_sync_bridge: RTL and testbench

Downstream consumer of the two-way mutex merge's `o_driveNext`/`i_freeNext` pair. Captures each asynchronous drive event, brings it into the `clk` domain and presents it as a valid/ready request to synchronous logic. Once the transfer completes, it returns a registered free pulse to the merge. It also keeps a wrapping transfer counter and a sticky overrun flag for drive events that arrive while a request is still in flight.

---
 rtl/drive_sync_bridge.sv | 102 ++++++++++
 tb/tb_drive_sync_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sync_bridge.sv
// Brings asynchronous drive events from the mutex merge into the clk domain,
// presents them as a valid/ready request and returns a registered free pulse.
`timescale 1ns/1ps

module drive_sync_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int FREE_W      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_drive,
  output logic             o_free,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_err_clr,
  output logic             o_err_overrun,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [1:0] {IDLE, VALID, FREE} state_t;

  logic                   tog_q, tog_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   tog_dly_q, tog_dly_d;
  logic                   evt;
  state_t                 state_q, state_d;
  logic [3:0]             free_cnt_q, free_cnt_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic                   free_q, free_d;

  // Only logic in the i_drive domain: one toggle per rising edge.
  always_comb tog_d = ~tog_q;

  always_ff @(posedge i_drive or negedge rst) begin
    if (!rst) tog_q <= 1'b0;
    else      tog_q <= tog_d;
  end

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tog_q};
    tog_dly_d = sync_q[SYNC_STAGES-1];
    evt       = sync_q[SYNC_STAGES-1] ^ tog_dly_q;
  end

  always_comb begin
    state_d    = state_q;
    free_cnt_d = free_cnt_q;
    count_d    = count_q;
    err_d      = err_q;
    if (i_err_clr) err_d = 1'b0;
    // Events outside IDLE are dropped and flagged; the set beats a clear.
    if (evt && state_q != IDLE) err_d = 1'b1;
    case (state_q)
      IDLE: if (evt) state_d = VALID;
      VALID: begin
        if (i_ready) begin
          count_d    = count_q + CNT_W'(1);
          free_cnt_d = 4'(FREE_W);
          state_d    = FREE;
        end
      end
      FREE: begin
        free_cnt_d = free_cnt_q - 4'd1;
        if (free_cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == VALID);
    free_d  = (state_d == FREE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      tog_dly_q  <= 1'b0;
      state_q    <= IDLE;
      free_cnt_q <= 4'd0;
      count_q    <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      free_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      tog_dly_q  <= tog_dly_d;
      state_q    <= state_d;
      free_cnt_q <= free_cnt_d;
      count_q    <= count_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      free_q     <= free_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_free        = free_q;
  assign o_err_overrun = err_q;
  assign o_count       = count_q;

endmodule

// File: tb/tb_drive_sync_bridge.sv
// Self-checking bench: a default instance and a SYNC_STAGES=4/FREE_W=1/CNT_W=4
// instance, both checked against a transaction-level model of transfers.
`timescale 1ns/1ps

module tb_drive_sync_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  drive, ready, clr;
  logic [1:0]  valid, free, err;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int errors = 0;
  int checks = 0;
  int model_cnt [2];
  bit model_err [2];

  always #5 clk = ~clk;

  drive_sync_bridge dut_a (
    .clk(clk), .rst(rst), .i_drive(drive[0]), .o_free(free[0]),
    .o_valid(valid[0]), .i_ready(ready[0]), .i_err_clr(clr[0]),
    .o_err_overrun(err[0]), .o_count(cnt0)
  );

  drive_sync_bridge #(.SYNC_STAGES(4), .FREE_W(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .i_drive(drive[1]), .o_free(free[1]),
    .o_valid(valid[1]), .i_ready(ready[1]), .i_err_clr(clr[1]),
    .o_err_overrun(err[1]), .o_count(cnt1)
  );

  function automatic int syncOf(input int sel);
    return sel ? 4 : 2;
  endfunction

  function automatic int freeOf(input int sel);
    return sel ? 1 : 2;
  endfunction

  function automatic int maskOf(input int sel);
    return sel ? 15 : 65535;
  endfunction

  function automatic logic [31:0] countOf(input int sel);
    return sel ? {28'b0, cnt1} : {16'b0, cnt0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising edge of i_drive at a random phase strictly between clk edges
  task automatic raiseDrive(input int sel);
    #($urandom_range(1, 7));
    drive[sel] = 1'b1;
  endtask

  task automatic waitValid(input int sel, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
      if (edges == 2) drive[sel] = 1'b0;
    end while (!valid[sel] && edges < 16);
  endtask

  // One complete transfer from IDLE, consumer stalled for 'stall' cycles
  task automatic applyStimulus(input int sel, input int stall);
    int edges, vcyc, fl;
    ready[sel] = (stall == 0);
    raiseDrive(sel);
    waitValid(sel, edges);
    checkOutput($sformatf("latency%0d", sel),
                valid[sel] && edges >= syncOf(sel) + 1 && edges <= syncOf(sel) + 2, 1);
    vcyc = 1;
    repeat (stall) begin
      tick();
      if (valid[sel]) vcyc++;
    end
    ready[sel] = 1'b1;
    tick();
    checkOutput($sformatf("valid_len%0d", sel), vcyc, stall + 1);
    checkOutput($sformatf("free_start%0d", sel), {valid[sel], free[sel]}, 2'b01);
    model_cnt[sel] = (model_cnt[sel] + 1) & maskOf(sel);
    fl = 0;
    while (free[sel] && fl < 20) begin
      fl++;
      tick();
    end
    checkOutput($sformatf("free_len%0d", sel), fl, freeOf(sel));
    checkOutput($sformatf("count%0d", sel), countOf(sel), model_cnt[sel]);
    checkOutput($sformatf("overrun%0d", sel), err[sel], model_err[sel]);
  endtask

  task automatic quietCheck(input int sel, input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (valid[sel]) seen = 1'b1;
    end
    checkOutput(tag, seen, 0);
  endtask

  task automatic waitFreeEnd(input int sel);
    int n;
    n = 0;
    while (free[sel] && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int edges;
    rst = 1'b0;
    drive = '0;
    ready = '0;
    clr = '0;
    for (int i = 0; i < 2; i++) begin
      model_cnt[i] = 0;
      model_err[i] = 1'b0;
    end

    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("rst_valid%0d", s), valid[s], 0);
      checkOutput($sformatf("rst_free%0d", s), free[s], 0);
      checkOutput($sformatf("rst_err%0d", s), err[s], 0);
      checkOutput($sformatf("rst_count%0d", s), countOf(s), 0);
    end
    rst = 1'b1;
    tick();

    applyStimulus(0, 0);
    applyStimulus(0, 20);

    // Second drive lands while the request is still in VALID
    ready[0] = 1'b0;
    raiseDrive(0);
    waitValid(0, edges);
    raiseDrive(0);
    tick();
    tick();
    drive[0] = 1'b0;
    repeat (6) tick();
    checkOutput("ovr_valid_hold", valid[0], 1);
    checkOutput("ovr_flag", err[0], 1);
    ready[0] = 1'b1;
    tick();
    checkOutput("ovr_free", free[0], 1);
    model_cnt[0]++;
    model_err[0] = 1'b1;
    waitFreeEnd(0);
    quietCheck(0, 10, "ovr_no_second");
    checkOutput("ovr_count", countOf(0), model_cnt[0]);
    checkOutput("ovr_sticky", err[0], 1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    model_err[0] = 1'b0;
    checkOutput("ovr_clear", err[0], 0);

    // New event sampled in the first FREE cycle together with a clear
    ready[0] = 1'b0;
    raiseDrive(0);
    waitValid(0, edges);
    raiseDrive(0);
    tick();
    ready[0] = 1'b1;
    tick();
    checkOutput("setwin_free", free[0], 1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    drive[0] = 1'b0;
    checkOutput("setwin_flag", err[0], 1);
    model_cnt[0]++;
    model_err[0] = 1'b1;
    waitFreeEnd(0);
    quietCheck(0, 8, "setwin_discard");
    checkOutput("setwin_count", countOf(0), model_cnt[0]);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    model_err[0] = 1'b0;
    checkOutput("setwin_clear", err[0], 0);

    // Reset asserted in the first FREE cycle
    ready[0] = 1'b1;
    raiseDrive(0);
    waitValid(0, edges);
    tick();
    checkOutput("midrst_pre_free", free[0], 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_free", free[0], 0);
    checkOutput("midrst_valid", valid[0], 0);
    checkOutput("midrst_count", countOf(0), 0);
    for (int i = 0; i < 2; i++) begin
      model_cnt[i] = 0;
      model_err[i] = 1'b0;
    end
    #3;
    rst = 1'b1;
    tick();
    quietCheck(0, 10, "midrst_quiet");
    applyStimulus(0, 0);
    checkOutput("midrst_count_one", countOf(0), 1);

    for (int i = 0; i < 20; i++) applyStimulus(0, $urandom_range(0, 4));

    for (int i = 0; i < 17; i++) applyStimulus(1, $urandom_range(0, 2));
    checkOutput("wrap_end", countOf(1), 1);
    checkOutput("wrap_no_ovr", err[1], 0);

    for (int i = 0; i < 1000; i++) applyStimulus(1, $urandom_range(0, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    errors++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
